// File: rtl/mem_backing_resp_pkg.sv
// Shared definitions for the cache miss/fill interface between the cache
// controller and the backing-memory responder.
package mem_backing_resp_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_backing_array.sv
// Single-port RAM with synchronous clear, registered read port and live taps
// of the first four words.
module mem_backing_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] ram0_o,
  output logic [DATA_W-1:0] ram1_o,
  output logic [DATA_W-1:0] ram2_o,
  output logic [DATA_W-1:0] ram3_o
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] mem_d [Depth];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    mem_d = mem_q;
    if (we_i) mem_d[addr_i] = wdata_i;
  end

  // rdata only moves on a read strobe, so it holds across writes and idle.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = mem_q[addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      mem_q   <= '{default: '0};
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign ram0_o  = mem_q[ADDR_W'(0)];
  assign ram1_o  = mem_q[ADDR_W'(1)];
  assign ram2_o  = mem_q[ADDR_W'(2)];
  assign ram3_o  = mem_q[ADDR_W'(3)];

endmodule

// File: rtl/mem_backing_resp.sv
// Backing-memory responder: accepts one read/write request at a time and
// acknowledges it LATENCY cycles after acceptance.
module mem_backing_resp
  import mem_backing_resp_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LATENCY = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic [DATA_W-1:0] ram0,
  output logic [DATA_W-1:0] ram1,
  output logic [DATA_W-1:0] ram2,
  output logic [DATA_W-1:0] ram3
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_we, mem_re;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          rw_d    = rw;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= RW_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Read on the edge entering RESP so rdata is valid in the ack cycle; *_d
  // carries the just-accepted request when LATENCY is 1.
  assign mem_re = (state_d == S_RESP) && (state_q != S_RESP) && (rw_d == RW_READ);
  assign mem_we = (state_q == S_RESP) && (rw_q == RW_WRITE);
  assign ack    = (state_q == S_RESP);
  assign busy   = (state_q != S_IDLE);

  mem_backing_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk_i   (clk),
    .clr_i   (clr),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (addr_d),
    .wdata_i (wdata_q),
    .rdata_o (rdata),
    .ram0_o  (ram0),
    .ram1_o  (ram1),
    .ram2_o  (ram2),
    .ram3_o  (ram3)
  );

endmodule

// File: tb/tb_mem_backing_resp.sv
// Randomized self-checking bench for mem_backing_resp against a word-array
// reference model, plus a LATENCY=1 instance.
module tb_mem_backing_resp;

  localparam int Lat = 3;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       req = 1'b0, rw = 1'b0;
  logic [7:0] addr = '0, wdata = '0;
  logic [7:0] rdata, ram0, ram1, ram2, ram3;
  logic       ack, busy;

  logic       req1 = 1'b0, rw1 = 1'b0;
  logic [7:0] addr1 = '0, wdata1 = '0;
  logic [7:0] rdata1, r10, r11, r12, r13;
  logic       ack1, busy1;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [256];
  logic [7:0] exp_rdata;

  always #5 clk = ~clk;

  mem_backing_resp #(.ADDR_W(8), .DATA_W(8), .LATENCY(Lat)) u_dut (
    .clk(clk), .clr(clr), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy),
    .ram0(ram0), .ram1(ram1), .ram2(ram2), .ram3(ram3)
  );

  mem_backing_resp #(.ADDR_W(8), .DATA_W(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .clr(clr), .req(req1), .rw(rw1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ack(ack1), .busy(busy1),
    .ram0(r10), .ram1(r11), .ram2(r12), .ram3(r13)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    exp_rdata = 8'h00;
  endtask

  task automatic check_taps();
    check_eq("ram0", ram0, model[0]);
    check_eq("ram1", ram1, model[1]);
    check_eq("ram2", ram2, model[2]);
    check_eq("ram3", ram3, model[3]);
  endtask

  // Called at a negedge while idle; returns at the negedge of the cycle after ack.
  task automatic txn(input logic w, input logic [7:0] a, input logic [7:0] d, input bit noise);
    int  n;
    bit  got;
    req = 1'b1; rw = w; addr = a; wdata = d;
    @(negedge clk);
    if (noise) begin
      rw = ~w; addr = 8'($urandom); wdata = 8'($urandom);
    end else begin
      req = 1'b0;
    end
    n   = 1;
    got = 1'b0;
    while (n <= 20 && !got) begin
      check_eq("busy_in_flight", busy, 1);
      if (ack) begin
        got = 1'b1;
        check_eq("ack_latency", n, Lat);
        if (w == 1'b0) exp_rdata = model[a];
        check_eq("rdata_at_ack", rdata, exp_rdata);
      end
      @(negedge clk);
      req = 1'b0;
      n++;
    end
    if (!got) check_eq("ack_timeout", 0, 1);
    if (w == 1'b1) model[a] = d;
    check_eq("busy_after_ack", busy, 0);
    check_eq("ack_after_ack", ack, 0);
    check_eq("rdata_held", rdata, exp_rdata);
    check_taps();
  endtask

  initial begin
    int ack_t[$];
    int k;
    model_reset();

    // Reset
    @(negedge clk);
    clr = 1'b1;
    req = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    req = 1'b0;
    check_eq("rst_ack", ack, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rdata", rdata, 0);
    check_taps();

    // Directed plan items
    txn(1'b0, 8'h0F, 8'h00, 1'b0);
    txn(1'b1, 8'h0F, 8'hAF, 1'b0);
    txn(1'b0, 8'h0F, 8'h00, 1'b0);
    txn(1'b1, 8'h01, 8'hE0, 1'b0);
    txn(1'b0, 8'h0F, 8'h00, 1'b1);
    check_eq("ignored_write_ram2", ram2, 8'h00);

    // Back-to-back with req held high: write 3<-11, read 3, write, read
    req = 1'b1; rw = 1'b1; addr = 8'h03; wdata = 8'h11;
    k = 0;
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      if (ack) begin
        ack_t.push_back(t);
        if (rw == 1'b1) begin
          // inputs already switched to the next txn; kind is by ack order
        end
        if ((ack_t.size() % 2) == 0) check_eq("b2b_read_data", rdata, 8'h11);
      end
      if (t % 4 == 1) begin
        k++;
        rw = (k % 2 == 1) ? 1'b0 : 1'b1;
      end
      if (t == 16) req = 1'b0;
    end
    model[3] = 8'h11;
    exp_rdata = 8'h11;
    check_eq("b2b_ack_count", ack_t.size(), 4);
    for (int i = 1; i < ack_t.size(); i++)
      check_eq("b2b_spacing", ack_t[i] - ack_t[i-1], Lat + 1);
    if (ack_t.size() > 0) check_eq("b2b_first_ack", ack_t[0], Lat);
    check_taps();

    // Reset in the middle of a write
    req = 1'b1; rw = 1'b1; addr = 8'h00; wdata = 8'h55;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ram0", ram0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      check_eq("abort_no_ack", ack, 0);
      @(negedge clk);
    end
    txn(1'b0, 8'h00, 8'h00, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic       w;
      logic [7:0] a;
      logic [7:0] d;
      w = 1'($urandom);
      a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      d = 8'($urandom);
      txn(w, a, d, $urandom_range(0, 2) == 0);
      repeat ($urandom_range(0, 2)) begin
        check_eq("idle_busy", busy, 0);
        @(negedge clk);
      end
    end

    // LATENCY=1 instance
    req1 = 1'b1; rw1 = 1'b1; addr1 = 8'h05; wdata1 = 8'h5A;
    @(negedge clk);
    req1 = 1'b0;
    check_eq("l1_wr_ack", ack1, 1);
    check_eq("l1_wr_busy", busy1, 1);
    @(negedge clk);
    check_eq("l1_wr_busy_done", busy1, 0);
    req1 = 1'b1; rw1 = 1'b0; addr1 = 8'h05;
    @(negedge clk);
    req1 = 1'b0;
    check_eq("l1_rd_ack", ack1, 1);
    check_eq("l1_rd_busy", busy1, 1);
    check_eq("l1_rd_data", rdata1, 8'h5A);
    @(negedge clk);
    check_eq("l1_rd_ack_done", ack1, 0);
    check_eq("l1_rd_busy_done", busy1, 0);
    check_eq("l1_rdata_held", rdata1, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_backing_resp.md
Name: mem_backing_resp

Overview:
- Backing-memory responder: the slave end of the cache miss/fill interface.
- The cache controller issues single-word read (fill) and write (write-through/evict) requests on a req/ack handshake.
- The block services each request after a fixed, parameterised access latency, modelling slow main RAM behind the 4-entry LRU cache.
- Exposes the first four RAM words for bench/board observation.

Parameters:
ADDR_W, 8, address width; RAM depth is 2**ADDR_W words
DATA_W, 8, data word width
LATENCY, 3, cycles from request acceptance to ack (legal range 1..15)

Ports:
clk  input  1  system clock, rising-edge
clr  input  1  synchronous active-high reset
req  input  1  request valid from cache controller
rw  input  1  0 = read, 1 = write
addr  input  ADDR_W  word address
wdata  input  DATA_W  write data
rdata  output  DATA_W  read data, valid in ack cycle, held until next read ack
ack  output  1  one-cycle completion pulse
busy  output  1  transaction in flight
ram0  output  DATA_W  live content of word 0
ram1  output  DATA_W  live content of word 1
ram2  output  DATA_W  live content of word 2
ram3  output  DATA_W  live content of word 3

Behaviour:
- Reset: clr sampled high at a rising edge sets the following:
  - state IDLE; ack=0, busy=0, rdata=0, latency counter=0.
  - All RAM words cleared to 0.
  - clr overrides req in the same cycle.
- States:
  - IDLE -> WAIT: on req=1; latch rw, addr and wdata into internal registers; load counter with LATENCY-1.
  - WAIT: decrement the counter each cycle. When the counter is 0, go to RESP. With LATENCY=1, skip WAIT (IDLE -> RESP directly).
  - RESP: ack=1 for exactly this cycle; go to IDLE at the next edge.
- Timing:
  - The req edge counts as cycle 0; ack is high in cycle LATENCY.
  - busy is high from cycle 1 through the ack cycle inclusive.
- Read:
  - rdata is registered from RAM[latched addr] so it is valid during the ack cycle.
  - rdata holds its value until the next read ack or reset.
  - Writes do not change rdata.
- Write:
  - RAM[latched addr] <= latched wdata at the edge that ends the ack cycle.
  - A read accepted the cycle after ack returns the new value.
- req while busy: ignored. Input changes after acceptance have no effect, because the latched values are used.
- Back-to-back: if req is held high continuously, the next transaction is accepted in the IDLE cycle after ack. Minimum issue interval is LATENCY+1 cycles.
- Reset mid-transaction: the transaction is aborted with no ack and no RAM write; the block is IDLE the cycle after clr.
- Address wrap: none. The full 2**ADDR_W space is backed, so every address is legal.
- ram0..ram3: combinational views of RAM words 0..3. They reflect a write from the edge it commits.

Decomposition:
- Shared package holds:
  - state encoding constants: S_IDLE=2'd0, S_WAIT=2'd1, S_RESP=2'd2
  - RW_READ=1'b0, RW_WRITE=1'b1
  - default ADDR_W/DATA_W, so the cache controller and the responder agree on the interface.
- One natural sub-module: mem_backing_array. It holds the synchronous-clear, single-port RAM with a registered read port and the ram0..ram3 taps.
- The handshake FSM and latency counter stay in the top module.

Test Plan:
- Reset then read: clr for 2 cycles, req=1 rw=0 addr=8'h0F for 1 cycle -> ack pulses in cycle 3 after acceptance, rdata=8'h00, busy high in cycles 1-3 only.
- Write/readback: write addr=8'h0F wdata=8'hAF; after ack, read 8'h0F -> rdata=8'hAF. Write addr=8'h01 wdata=8'hE0 -> ram1=8'hE0 the cycle after ack.
- Busy ignore: accept read of 8'h0F, then in cycle 1 drive req=1 rw=1 addr=8'h02 wdata=8'hC0 for one cycle -> exactly one ack; ram2 stays 8'h00; rdata returns the 8'h0F content.
- Back-to-back: req held high with alternating writes 8'h03<-8'h11 and read 8'h03 -> acks spaced LATENCY+1=4 cycles apart; the read returns 8'h11.
- Reset mid-op: accept write addr=8'h00 wdata=8'h55, assert clr in cycle 2 -> no ack, ram0=8'h00, busy=0 the next cycle. A following read of 8'h00 returns 8'h00.
- LATENCY=1 instance: read request -> ack in the cycle immediately after acceptance; busy high for exactly 1 cycle.
